// File: rtl/param_ram_sweep_if.sv
// param_ram_sweep_if: write/read/clear bus of the settings RAM, driven by the master and served by the RAM.
interface param_ram_sweep_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [DATA_W-1:0] in;
  logic [ADDR_W-1:0] w_addr;
  logic              CS;
  logic [ADDR_W-1:0] r_addr;
  logic              RW;
  logic              clr;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              busy;
  logic              addr_err;
  modport master (
    output in, w_addr, CS, r_addr, RW, clr,
    input  out, out_valid, busy, addr_err
  );
  modport slave (
    input  in, w_addr, CS, r_addr, RW, clr,
    output out, out_valid, busy, addr_err
  );
endinterface

// File: rtl/param_ram_sweep.sv
// param_ram_sweep: parametrised dual-port settings RAM with clear sweep, read-valid and address-error flags.
// Define RAM_BYPASS_EN for write-first collision data; read-first otherwise.
module param_ram_sweep #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 3,
  parameter int                DEPTH    = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic               clk_RAM,
  input logic               rst,
  param_ram_sweep_if.slave  bus
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              w_ok, r_ok, user_we, rd, we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd, rdata;
  always_comb begin
    w_ok    = {1'b0, bus.w_addr} < LIM;
    r_ok    = {1'b0, bus.r_addr} < LIM;
    user_we = state == RUN && !bus.CS && !bus.clr;
    rd      = state == RUN && bus.RW;
    we      = state == CLEAR || (user_we && w_ok);
    wa      = state == CLEAR ? cnt : bus.w_addr;
    wd      = state == CLEAR ? INIT_VAL : bus.in;
`ifdef RAM_BYPASS_EN
    rdata   = !r_ok ? INIT_VAL :
              (user_we && w_ok && bus.w_addr == bus.r_addr) ? bus.in : mem[bus.r_addr];
`else
    rdata   = r_ok ? mem[bus.r_addr] : INIT_VAL;
`endif
    state_n = state == CLEAR ? (cnt == LAST ? RUN : CLEAR) : (bus.clr ? CLEAR : RUN);
    cnt_n   = (state == CLEAR && cnt != LAST) ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk_RAM or posedge rst) begin
    if (rst) begin
      state         <= CLEAR;
      cnt           <= '0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.addr_err  <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      if (rd) bus.out <= rdata;
      bus.out_valid <= rd;
      bus.addr_err  <= (user_we && !w_ok) || (rd && !r_ok);
    end
  end
  // Array is deliberately unreset; the sweep is what initialises it.
  always_ff @(posedge clk_RAM) begin
    if (we) mem[wa] <= wd;
  end
  assign bus.busy = state == CLEAR;
endmodule

// File: tb/tb_param_ram_sweep.sv
// tb_param_ram_sweep: directed vector bench for param_ram_sweep (DEPTH=8 and DEPTH=5 instances).
module tb_param_ram_sweep;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
`ifdef RAM_BYPASS_EN
  localparam logic [7:0] COL = 8'h5A;
`else
  localparam logic [7:0] COL = 8'h11;
`endif
  param_ram_sweep_if #(.DATA_W(8), .ADDR_W(3)) b8 ();
  param_ram_sweep_if #(.DATA_W(8), .ADDR_W(3)) b5 ();
  param_ram_sweep #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .INIT_VAL(8'h00)) u8 (
    .clk_RAM(clk), .rst(rst), .bus(b8.slave));
  param_ram_sweep #(.DATA_W(8), .ADDR_W(3), .DEPTH(5), .INIT_VAL(8'h3C)) u5 (
    .clk_RAM(clk), .rst(rst), .bus(b5.slave));
  typedef struct {
    logic       cs;
    logic [2:0] wa;
    logic [7:0] d;
    logic       rw;
    logic [2:0] ra;
    logic [7:0] eo;
    logic       ev;
  } vec_t;
  vec_t v[16];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive8(input logic cs, input logic [2:0] wa, input logic [7:0] d,
                        input logic rw, input logic [2:0] ra);
    @(negedge clk);
    b8.CS = cs; b8.w_addr = wa; b8.in = d; b8.RW = rw; b8.r_addr = ra;
    @(posedge clk);
    #1;
  endtask
  task automatic drive5(input logic cs, input logic [2:0] wa, input logic [7:0] d,
                        input logic rw, input logic [2:0] ra);
    @(negedge clk);
    b5.CS = cs; b5.w_addr = wa; b5.in = d; b5.RW = rw; b5.r_addr = ra;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle8(output int n);
    n = 0;
    while (b8.busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  initial begin
    int n8, n5, n, bad;
    rst = 1'b1;
    b8.CS = 1'b1; b8.w_addr = '0; b8.in = '0; b8.RW = 1'b0; b8.r_addr = '0; b8.clr = 1'b0;
    b5.CS = 1'b1; b5.w_addr = '0; b5.in = '0; b5.RW = 1'b0; b5.r_addr = '0; b5.clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(b8.out), 32'h00);
    check("rst_valid", 32'(b8.out_valid), 32'h0);
    check("rst_err", 32'(b8.addr_err), 32'h0);
    check("rst_busy8", 32'(b8.busy), 32'h1);
    check("rst_busy5", 32'(b5.busy), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    n8 = 0; n5 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (!b8.busy && n8 == 0) n8 = k;
      if (!b5.busy && n5 == 0) n5 = k;
    end
    check("sweep_len8", 32'(n8), 32'd8);
    check("sweep_len5", 32'(n5), 32'd5);
    for (int i = 0; i < 8; i++) v[i] = '{1'b1, 3'd0, 8'h00, 1'b1, 3'(i), 8'h00, 1'b1};
    v[8]  = '{1'b0, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b0};
    v[9]  = '{1'b1, 3'd0, 8'h00, 1'b1, 3'd3, 8'hA5, 1'b1};
    v[10] = '{1'b1, 3'd0, 8'h00, 1'b0, 3'd0, 8'hA5, 1'b0};
    v[11] = '{1'b0, 3'd2, 8'h11, 1'b0, 3'd0, 8'hA5, 1'b0};
    v[12] = '{1'b0, 3'd2, 8'h5A, 1'b1, 3'd2, COL,   1'b1};
    v[13] = '{1'b1, 3'd0, 8'h00, 1'b1, 3'd2, 8'h5A, 1'b1};
    v[14] = '{1'b0, 3'd7, 8'h77, 1'b1, 3'd3, 8'hA5, 1'b1};
    v[15] = '{1'b1, 3'd0, 8'h00, 1'b1, 3'd7, 8'h77, 1'b1};
    for (int i = 0; i < 16; i++) begin
      drive8(v[i].cs, v[i].wa, v[i].d, v[i].rw, v[i].ra);
      check($sformatf("vec%0d_out", i), 32'(b8.out), 32'(v[i].eo));
      check($sformatf("vec%0d_valid", i), 32'(b8.out_valid), 32'(v[i].ev));
    end
    for (int i = 0; i < 8; i++) drive8(1'b0, 3'(i), 8'hFF, 1'b0, 3'd0);
    @(negedge clk);
    b8.clr = 1'b1; b8.CS = 1'b0; b8.w_addr = 3'd0; b8.in = 8'h99; b8.RW = 1'b1; b8.r_addr = 3'd7;
    @(posedge clk);
    #1;
    check("clr_read_out", 32'(b8.out), 32'hFF);
    check("clr_read_valid", 32'(b8.out_valid), 32'h1);
    check("clr_busy", 32'(b8.busy), 32'h1);
    @(negedge clk);
    b8.clr = 1'b0; b8.CS = 1'b0; b8.w_addr = 3'd1; b8.in = 8'hAB; b8.RW = 1'b1; b8.r_addr = 3'd1;
    n = 0; bad = 0;
    while (b8.busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (b8.out_valid || b8.out !== 8'hFF) bad++;
    end
    check("clr_sweep_len", 32'(n), 32'd8);
    check("busy_access_ignored", 32'(bad), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive8(1'b1, 3'd0, 8'h00, 1'b1, 3'(i));
      check($sformatf("cleared%0d", i), 32'(b8.out), 32'h00);
    end
    for (int i = 0; i < 5; i++) drive5(1'b0, 3'(i), 8'(16 + i), 1'b0, 3'd0);
    drive5(1'b0, 3'd6, 8'hEE, 1'b0, 3'd0);
    check("oor_wr_err", 32'(b5.addr_err), 32'h1);
    drive5(1'b1, 3'd0, 8'h00, 1'b0, 3'd0);
    check("oor_wr_err_end", 32'(b5.addr_err), 32'h0);
    drive5(1'b1, 3'd0, 8'h00, 1'b1, 3'd6);
    check("oor_rd_err", 32'(b5.addr_err), 32'h1);
    check("oor_rd_out", 32'(b5.out), 32'h3C);
    check("oor_rd_valid", 32'(b5.out_valid), 32'h1);
    drive5(1'b1, 3'd0, 8'h00, 1'b0, 3'd0);
    check("oor_rd_err_end", 32'(b5.addr_err), 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive5(1'b1, 3'd0, 8'h00, 1'b1, 3'(i));
      check($sformatf("d5_word%0d", i), 32'(b5.out), 32'(16 + i));
      check($sformatf("d5_err%0d", i), 32'(b5.addr_err), 32'h0);
    end
    drive8(1'b0, 3'd3, 8'hA5, 1'b0, 3'd0);
    drive8(1'b1, 3'd0, 8'h00, 1'b1, 3'd3);
    check("pre_rst_out", 32'(b8.out), 32'hA5);
    @(negedge clk);
    b8.clr = 1'b1; b8.RW = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b8.clr = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid_sweep_out_held", 32'(b8.out), 32'hA5);
    rst = 1'b1;
    #1;
    check("async_rst_out", 32'(b8.out), 32'h00);
    check("async_rst_busy", 32'(b8.busy), 32'h1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_idle8(n);
    check("restart_sweep_len", 32'(n), 32'd8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
